// File: rtl/stack_prog_ctrl_pkg.sv
// Shared constants for the stack_machine program loader / run controller.
// Optional feature macro: STACK_PROG_CTRL_TIMEOUT_EN (see run_watchdog).
package stack_prog_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_OVERRUN = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    // Instruction word layout: {op, val}
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 8;
    localparam int unsigned VAL_MSB = 7;
    localparam int unsigned VAL_LSB = 0;

    typedef struct packed {
        logic [OP_MSB-OP_LSB:0]   op;
        logic [VAL_MSB-VAL_LSB:0] val;
    } inst_t;

endpackage

// File: rtl/stack_prog_ctrl_watchdog.sv
// Saturating run-cycle counter; timeout compare exists only with
// STACK_PROG_CTRL_TIMEOUT_EN defined.
module run_watchdog #(
    parameter int unsigned CYC_W      = 16,
    parameter int unsigned MAX_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CYC_W-1:0] cycles_o,
    output logic             timeout_c
);

    localparam logic [CYC_W-1:0] CNT_MAX = '1;

    logic [CYC_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CYC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycles_o = cnt_q;

`ifdef STACK_PROG_CTRL_TIMEOUT_EN
    // Fires in the cycle whose closing edge brings the count to MAX_CYCLES.
    localparam logic [CYC_W-1:0] TMO_PREV = CYC_W'(MAX_CYCLES - 1);
    assign timeout_c = en_i && (cnt_q == TMO_PREV);
`else
    logic unused_max;
    assign unused_max = (MAX_CYCLES == 0);
    assign timeout_c  = 1'b0;
`endif

endmodule

// File: rtl/stack_prog_ctrl.sv
// Program loader and run controller for one stack_machine core.
// Optional watchdog timeout: define STACK_PROG_CTRL_TIMEOUT_EN.
module stack_prog_ctrl
    import stack_prog_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned INST_W     = 16,
    parameter int unsigned CYC_W      = 16,
    parameter int unsigned MAX_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [INST_W-1:0] load_data,
    input  logic              load_last,
    input  logic              start,
    input  logic              clear,
    input  logic [ADDR_W-1:0] halt_pc,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              cpu_rstN,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              busy,
    output logic              done,
    output logic [1:0]        fault,
    output logic [CYC_W-1:0]  cycles
);

    localparam int unsigned       LEN_W   = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]  prog_len_q, prog_len_d;
    logic              full_q, full_d;
    logic [1:0]        fault_q, fault_d;
    logic              busy_q, done_q, cpu_rst_n_q;
    logic              beat;
    logic              wd_clr, wd_en, wd_timeout;

    // Load stream is open only in IDLE until the program is full.
    assign load_ready = (state_q == ST_IDLE) && !full_q;
    assign beat       = load_valid && load_ready;
    assign imem_we    = beat;
    assign imem_addr  = wr_ptr_q;
    assign imem_wdata = load_data;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        full_d     = full_q;
        fault_d    = fault_q;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    prog_len_d = LEN_W'(wr_ptr_q) + LEN_W'(1);
                    if (load_last || (wr_ptr_q == PTR_MAX)) begin
                        full_d = 1'b1;
                    end
                    if (wr_ptr_q != PTR_MAX) begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end
                end else if (start && (prog_len_q != '0)) begin
                    state_d = ST_RUN;
                    fault_d = FAULT_NONE;
                    wd_clr  = 1'b1;
                end
                if (clear) begin
                    wr_ptr_d = '0;
                    full_d   = 1'b0;
                end
            end
            ST_RUN: begin
                wd_en = 1'b1;
                // Halt match beats overrun, which beats timeout.
                if (cpu_pc == halt_pc) begin
                    state_d = ST_DONE;
                end else if (LEN_W'(cpu_pc) >= prog_len_q) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_OVERRUN;
                end else if (wd_timeout) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            default: begin
                if (clear) begin
                    state_d  = ST_IDLE;
                    wr_ptr_d = '0;
                    full_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            prog_len_q  <= '0;
            full_q      <= 1'b0;
            fault_q     <= FAULT_NONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            prog_len_q  <= prog_len_d;
            full_q      <= full_d;
            fault_q     <= fault_d;
            busy_q      <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
            cpu_rst_n_q <= (state_d == ST_RUN);
        end
    end

    run_watchdog #(
        .CYC_W      (CYC_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rstN      (rstN),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .cycles_o  (cycles),
        .timeout_c (wd_timeout)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign fault    = fault_q;
    assign cpu_rstN = cpu_rst_n_q;

endmodule

// File: tb/tb_stack_prog_ctrl.sv
// Self-checking bench for stack_prog_ctrl; the core's pc is modelled as a
// scripted random trajectory and run outcomes come from a rule-level model.
module tb_stack_prog_ctrl;

    localparam int MAXC = 50;

    logic        clk = 1'b0;
    logic        rstN;
    logic        load_valid, load_ready, load_last;
    logic [15:0] load_data;
    logic        start, clear;
    logic [7:0]  halt_pc, cpu_pc;
    logic        imem_we, cpu_rstN, busy, done;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic [1:0]  fault;
    logic [15:0] cycles;

    int checks   = 0;
    int failures = 0;
    logic [7:0] pcq[$];

    stack_prog_ctrl #(
        .ADDR_W(8), .INST_W(16), .CYC_W(16), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rstN(rstN),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .start(start), .clear(clear), .halt_pc(halt_pc),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rstN(cpu_rstN), .cpu_pc(cpu_pc),
        .busy(busy), .done(done), .fault(fault), .cycles(cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Stream n words; optionally flag the last one and raise start on the first beat.
    task automatic load_prog(input int n, input bit use_last, input bit start_first);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = 16'($urandom);
            load_last  = use_last && (i == n - 1);
            start      = start_first && (i == 0);
            #1;
            chk("load_ready_beat", 32'(load_ready), 32'd1);
            chk("imem_we_beat", 32'(imem_we), 32'd1);
            chk("imem_addr", 32'(imem_addr), 32'(i));
            chk("imem_wdata", 32'(imem_wdata), 32'(load_data));
            tick();
            if (start_first && i == 0) chk("start_dropped_on_beat", 32'(busy), 32'd0);
            start = 1'b0;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        #1;
        chk("load_ready_after", 32'(load_ready), (use_last || n == 256) ? 32'd0 : 32'd1);
        chk("imem_we_idle", 32'(imem_we), 32'd0);
    endtask

    // Outcome from the rules: halt first, then overrun, then (optional) timeout.
    function automatic void model(input int len, input logic [7:0] halt,
                                  output int ecyc, output int eend, output logic [1:0] efault);
        ecyc = pcq.size(); eend = 0; efault = 2'd0;
        for (int j = 1; j <= pcq.size(); j++) begin
            if (pcq[j-1] == halt) begin
                ecyc = j; eend = 1; efault = 2'd0; return;
            end
            if (int'(pcq[j-1]) >= len) begin
                ecyc = j; eend = 2; efault = 2'd1; return;
            end
`ifdef STACK_PROG_CTRL_TIMEOUT_EN
            if (j == MAXC) begin
                ecyc = j; eend = 2; efault = 2'd2; return;
            end
`endif
        end
    endfunction

    task automatic run_prog(input string tag, input int len, input logic [7:0] halt);
        int ecyc, eend, n;
        logic [1:0] ef;
        model(len, halt, ecyc, eend, ef);
        halt_pc = halt;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        chk({tag, "_cpurst0"}, 32'(cpu_rstN), 32'd1);
        chk({tag, "_cyc0"}, 32'(cycles), 32'd0);
        n = 0;
        while (n < ecyc) begin
            cpu_pc = pcq[n];
            n++;
            tick();
            if (n < ecyc) chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
        end
        chk({tag, "_busy"}, 32'(busy), (eend == 0) ? 32'd1 : 32'd0);
        chk({tag, "_done"}, 32'(done), (eend == 1) ? 32'd1 : 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'(ef));
        chk({tag, "_cycles"}, 32'(cycles), 32'(ecyc));
        chk({tag, "_cpurst"}, 32'(cpu_rstN), (eend == 0) ? 32'd1 : 32'd0);
        if (eend != 0) begin
            repeat (3) begin
                cpu_pc = 8'($urandom);
                tick();
            end
            chk({tag, "_cycles_hold"}, 32'(cycles), 32'(ecyc));
            chk({tag, "_fault_hold"}, 32'(fault), 32'(ef));
        end
    endtask

    initial begin
        int len;
        logic [7:0] halt;
        rstN = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        start = 1'b0; clear = 1'b0; halt_pc = '0; cpu_pc = '0;
        #12;
        chk("rst_cpu_rstN", 32'(cpu_rstN), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        tick();
        rstN = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cycles", 32'(cycles), 32'd0);

        // Start with nothing loaded is ignored.
        start = 1'b1; tick(); start = 1'b0;
        chk("start_empty", 32'(busy), 32'd0);

        // 21-word program, halt at 25.
        load_prog(21, 1'b1, 1'b0);
        pcq.delete();
        repeat ($urandom_range(3, 15)) pcq.push_back(8'($urandom_range(0, 20)));
        pcq.push_back(8'd25);
        run_prog("run21", 21, 8'd25);

        // Clear then rerun the retained program.
        pulse_clear();
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_ready", 32'(load_ready), 32'd1);
        run_prog("rerun21", 21, 8'd25);

        // Start on a load beat is dropped; then overrun past a 2-word program.
        pulse_clear();
        load_prog(2, 1'b1, 1'b1);
        pcq.delete();
        repeat ($urandom_range(0, 6)) pcq.push_back(8'($urandom_range(0, 1)));
        pcq.push_back(8'd9);
        run_prog("overrun", 2, 8'd200);

        // halt_pc = 0 ends after one RUN cycle.
        pulse_clear();
        pcq.delete();
        pcq.push_back(8'd0);
        run_prog("halt0", 2, 8'd0);

        // Randomized programs and trajectories.
        for (int it = 0; it < 8; it++) begin
            pulse_clear();
            len  = $urandom_range(1, 30);
            halt = 8'($urandom_range(0, 40));
            load_prog(len, 1'b1, 1'b0);
            pcq.delete();
            repeat ($urandom_range(0, 20)) pcq.push_back(8'($urandom_range(0, len - 1)));
            if ($urandom_range(0, 1) == 1) pcq.push_back(halt);
            else pcq.push_back(8'(len + $urandom_range(0, 20)));
            run_prog("rand", len, halt);
        end

        // Full 256-word memory without load_last; pc 255 is still in range.
        pulse_clear();
        load_prog(256, 1'b0, 1'b0);
        pcq.delete();
        pcq.push_back(8'd255);
        pcq.push_back(8'd0);
        run_prog("full256", 256, 8'd0);

        // Endless loop: timeout when enabled, otherwise still running.
        pulse_clear();
        load_prog(2, 1'b1, 1'b0);
        pcq.delete();
        for (int i = 0; i < 60; i++) pcq.push_back(8'(i % 2));
        run_prog("loop", 2, 8'd200);

`ifdef STACK_PROG_CTRL_TIMEOUT_EN
        pulse_clear();
        start = 1'b1; tick(); start = 1'b0;
        cpu_pc = 8'd0;
        repeat (3) tick();
`endif
        // Asynchronous reset mid-RUN.
        #2 rstN = 1'b0;
        #1;
        chk("arst_cpu_rstN", 32'(cpu_rstN), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cycles", 32'(cycles), 32'd0);
        chk("arst_ready", 32'(load_ready), 32'd1);
        tick();
        rstN = 1'b1;
        tick();
        chk("arst_idle", 32'(busy), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("arst_len_cleared", 32'(busy), 32'd0);

        load_prog(3, 1'b1, 1'b0);
        pcq.delete();
        pcq.push_back(8'd0); pcq.push_back(8'd1); pcq.push_back(8'd2);
        run_prog("post_rst", 3, 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_prog_ctrl.md
# stack_prog_ctrl

Program loader and run controller for the 8-bit `stack_machine` core. It accepts instruction words over a valid/ready stream and writes them into the core's instruction memory while holding the core in reset. On `start` it releases the core, watches its program counter for a halt address, and reports completion, cycle count and fault status. It sits between a host/test harness and one `stack_machine` instance.

## Interface
- `ADDR_W`, 8: instruction-address and pc width; depth = 2^ADDR_W.
- `INST_W`, 16: instruction word width, `{op[15:8], val[7:0]}`.
- `CYC_W`, 16: run-cycle counter width.
- `MAX_CYCLES`, 4096: watchdog limit; used only with the timeout feature.
- `clk` in 1: clock, rising edge.
- `rstN` in 1: asynchronous active-low reset.
- `load_valid` in 1: load word present.
- `load_ready` out 1: controller accepts a load word.
- `load_data` in INST_W: instruction word.
- `load_last` in 1: final word of the program (qualified by valid).
- `start` in 1: request run (level, sampled in IDLE).
- `clear` in 1: leave DONE/FAULT, rewind load pointer.
- `halt_pc` in ADDR_W: pc value that ends a run.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_addr` out ADDR_W: write address.
- `imem_wdata` out INST_W: write data.
- `cpu_rstN` out 1: core reset, active low.
- `cpu_pc` in ADDR_W: core program counter.
- `busy` out 1: state is RUN.
- `done` out 1: state is DONE.
- `fault` out 2: 0 none, 1 pc overrun, 2 timeout.
- `cycles` out CYC_W: RUN cycles of the last run.

## Operation
- States: IDLE, RUN, DONE, FAULT. Reset: IDLE, `wr_ptr`=0, `prog_len`=0, `full`=0, `cycles`=0, `fault`=0, `cpu_rstN`=0, all strobes 0, `load_ready`=1.
- IDLE: `load_ready` = !`full`. Beat (valid&ready): `imem_we`=1, `imem_addr`=`wr_ptr`, `imem_wdata`=`load_data` combinationally; at the edge `prog_len`<=`wr_ptr`+1, `wr_ptr`++. Beat with `load_last`, or at `wr_ptr`=2^ADDR_W−1, sets `full` (no pointer wrap).
- IDLE, `start`=1, `prog_len`>0, no beat in that cycle -> RUN; `cycles`<=0, `fault`<=0. `start` coinciding with a beat is dropped; the load wins. `start` with `prog_len`=0 is ignored.
- RUN: `cpu_rstN`=1, `load_ready`=0, `cycles` increments every edge (saturates at max). If `cpu_pc`==`halt_pc` -> DONE. Else if `cpu_pc`>=`prog_len` -> FAULT, code 1. Halt match has priority over overrun.
- DONE/FAULT: `cpu_rstN`=0, `cycles`/`fault` held. `clear` -> IDLE, `wr_ptr`<=0, `full`<=0, `prog_len` kept, so `start` reruns the retained program. A new load overwrites from address 0 and `prog_len` tracks it.
- `clear` in IDLE: rewinds `wr_ptr` and `full` only. `clear` in RUN: ignored.
- `rstN` low at any time: immediate return to reset values, and `cpu_rstN` drops asynchronously.

## Timing
- All outputs are registered except `imem_*` and `load_ready`, which are combinational from state, `full` and `load_valid`.
- `start` sampled at edge N: `cpu_rstN`=1 and `busy`=1 after N. The first pc compare is in the cycle after N, and `cycles`=1 after edge N+1.
- pc match in cycle k: DONE and `cpu_rstN`=0 after edge k. `cycles` counts the edge k as well.
- Load throughput: one word per cycle.

## Configuration
- `STACK_PROG_CTRL_TIMEOUT_EN` defined: in RUN, `cycles`==`MAX_CYCLES` without halt or overrun -> FAULT, code 2, at that edge. Halt and overrun take priority over timeout in the same cycle.
- Undefined: no timeout, `fault` is never 2, and `MAX_CYCLES` is unused.

## Structure
- `stack_prog_pkg`: state enum, fault-code constants (`FAULT_NONE`, `FAULT_OVERRUN`, `FAULT_TIMEOUT`), instruction field slicing constants (op/val positions).
- Sub-module `run_watchdog`: cycle counter with clear, enable, saturation and the optional timeout compare. The FSM, load pointer and pc checks stay in the top.

## Test plan
- Load 21-word program (`pushc 3` ... `j` at 20), `load_last` on word 20 -> 21 writes to addresses 0..20, `prog_len`=21, `load_ready` low after last beat.
- Same program, `halt_pc`=25, `start` -> RUN; core exits via `js` to 25 -> DONE, `fault`=0, `cpu_rstN` low, `cycles` nonzero and stable.
- 2-word program `pushc 9`, `j`, `halt_pc`=200 -> pc 9 >= 2 -> FAULT, code 1.
- `halt_pc`=0, `start` -> DONE after one RUN cycle, `cycles`=1.
- With `STACK_PROG_CTRL_TIMEOUT_EN`, `MAX_CYCLES`=50, infinite loop `pushc 0`, `j` -> FAULT code 2, `cycles`=50. `rstN` pulsed mid-RUN -> IDLE, `cpu_rstN`=0, `cycles`=0.
- `start` asserted in the same cycle as a load beat -> start dropped, still IDLE. `clear` then `start` after DONE -> rerun, same `cycles`.
